// File: rtl/ex_operand_stage.sv
// ex_operand_stage: operand-select pipeline register feeding the ALU.
// Resolves rs/rt from the register file or the ex/wb forwarding paths,
// stalls on load-use hazards and holds one instruction in a valid/ready slot.
module ex_operand_stage #(
    parameter int REG_AW      = 4,
    parameter int DATA_W      = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             in_opcode,
    input  logic [REG_AW-1:0]      in_rs,
    input  logic [REG_AW-1:0]      in_rt,
    input  logic [DATA_W-1:0]      in_rs_data,
    input  logic [DATA_W-1:0]      in_rt_data,
    input  logic [DATA_W-1:0]      in_imm,
    input  logic                   in_use_imm,
    input  logic [REG_AW-1:0]      in_rd,
    input  logic                   ex_fwd_valid,
    input  logic [REG_AW-1:0]      ex_fwd_reg,
    input  logic [DATA_W-1:0]      ex_fwd_data,
    input  logic                   ex_fwd_is_load,
    input  logic                   wb_fwd_valid,
    input  logic [REG_AW-1:0]      wb_fwd_reg,
    input  logic [DATA_W-1:0]      wb_fwd_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic [4:0]             alu_opcode,
    output logic [REG_AW-1:0]      out_rd,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    logic hazard;
    logic capture;

    // Index 0 is rs, index 1 is rt; both use the same resolution rules.
    logic [1:0][REG_AW-1:0] src_idx;
    logic [1:0][DATA_W-1:0] src_data;
    logic [1:0][DATA_W-1:0] resolved;
    logic [DATA_W-1:0]      b_val;

    assign src_idx  = {in_rt, in_rs};
    assign src_data = {in_rt_data, in_rs_data};

    // Register 0 is hardwired zero; the younger ex result beats the wb result.
    // A pending load on the ex path is never forwarded (that case is a hazard).
    for (genvar gi = 0; gi < 2; gi++) begin : g_resolve
        assign resolved[gi] =
            (src_idx[gi] == '0) ? '0 :
            (ex_fwd_valid && !ex_fwd_is_load && ex_fwd_reg == src_idx[gi]) ? ex_fwd_data :
            (wb_fwd_valid && wb_fwd_reg == src_idx[gi]) ? wb_fwd_data :
            src_data[gi];
    end

    assign b_val = in_use_imm ? in_imm : resolved[1];

    // Load-use hazard: an operand depends on a load whose data is not back yet.
    // rt only matters when the B operand actually comes from rt.
    assign hazard = in_valid && ex_fwd_valid && ex_fwd_is_load && (ex_fwd_reg != '0) &&
                    ((ex_fwd_reg == in_rs) || (!in_use_imm && ex_fwd_reg == in_rt));

    assign in_ready = !hazard && (!out_valid || out_ready);
    assign capture  = in_valid && in_ready && !flush;

    // Output slot: flush kills it, capture (re)loads it, a drain empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            out_rd     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid  <= 1'b1;
            alu_a      <= resolved[0];
            alu_b      <= b_val;
            alu_opcode <= in_opcode;
            out_rd     <= in_rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of load-use stall cycles; flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (hazard && stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: scoreboard bench for ex_operand_stage.
// Expected operands are pushed when a capture is predicted and compared
// while the slot is valid, popped when drained or flushed.
module tb_ex_operand_stage;

    localparam int REG_AW    = 4;
    localparam int DATA_W    = 32;
    localparam int SCW       = 3;
    localparam int STALL_MAX = 7;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_opcode;
    logic [REG_AW-1:0] in_rs, in_rt, in_rd;
    logic [DATA_W-1:0] in_rs_data, in_rt_data, in_imm;
    logic              in_use_imm;
    logic              ex_fwd_valid, ex_fwd_is_load;
    logic [REG_AW-1:0] ex_fwd_reg;
    logic [DATA_W-1:0] ex_fwd_data;
    logic              wb_fwd_valid;
    logic [REG_AW-1:0] wb_fwd_reg;
    logic [DATA_W-1:0] wb_fwd_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [4:0]        alu_opcode;
    logic [REG_AW-1:0] out_rd;
    logic [SCW-1:0]    stall_cnt;

    ex_operand_stage #(.REG_AW(REG_AW), .DATA_W(DATA_W), .STALL_CNT_W(SCW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rs(in_rs), .in_rt(in_rt), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_reg(ex_fwd_reg), .ex_fwd_data(ex_fwd_data),
        .ex_fwd_is_load(ex_fwd_is_load),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_reg(wb_fwd_reg), .wb_fwd_data(wb_fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .out_rd(out_rd),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [4:0]        op;
        logic [REG_AW-1:0] rd;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   m_valid  = 0;
    int   m_stall  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_resolve(input logic [REG_AW-1:0] s,
                                                        input logic [DATA_W-1:0] d);
        if (s == 0) return '0;
        if (ex_fwd_valid && !ex_fwd_is_load && ex_fwd_reg == s) return ex_fwd_data;
        if (wb_fwd_valid && wb_fwd_reg == s) return wb_fwd_data;
        return d;
    endfunction

    // One clock: check at the falling edge, update the model, advance past the rising edge.
    task automatic cycle();
        bit   hz, rdy, cap;
        exp_t e;
        @(negedge clk);
        hz  = in_valid && ex_fwd_valid && ex_fwd_is_load && ex_fwd_reg != 0 &&
              (ex_fwd_reg == in_rs || (!in_use_imm && ex_fwd_reg == in_rt));
        rdy = !hz && (!m_valid || out_ready);
        check("in_ready", in_ready, rdy);
        check("out_valid", out_valid, m_valid);
        check("stall_cnt", stall_cnt, m_stall);
        if (m_valid && sb.size() > 0) begin
            e = sb[0];
            check("alu_a", alu_a, e.a);
            check("alu_b", alu_b, e.b);
            check("alu_opcode", alu_opcode, e.op);
            check("out_rd", out_rd, e.rd);
            $display("txn t=%0t a=0x%0h b=0x%0h op=%0d rd=%0d ready=%0b",
                     $time, alu_a, alu_b, alu_opcode, out_rd, out_ready);
        end
        cap = in_valid && rdy && !flush;
        if (m_valid && (flush || out_ready) && sb.size() > 0) void'(sb.pop_front());
        if (cap) begin
            e.a  = model_resolve(in_rs, in_rs_data);
            e.b  = in_use_imm ? in_imm : model_resolve(in_rt, in_rt_data);
            e.op = in_opcode;
            e.rd = in_rd;
            sb.push_back(e);
        end
        if (flush)          m_valid = 0;
        else if (cap)       m_valid = 1;
        else if (out_ready) m_valid = 0;
        if (hz && m_stall != STALL_MAX) m_stall++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; in_opcode = 0; in_rs = 0; in_rt = 0; in_rd = 0;
        in_rs_data = 0; in_rt_data = 0; in_imm = 0; in_use_imm = 0;
        ex_fwd_valid = 0; ex_fwd_reg = 0; ex_fwd_data = 0; ex_fwd_is_load = 0;
        wb_fwd_valid = 0; wb_fwd_reg = 0; wb_fwd_data = 0;
        flush = 0; out_ready = 1;
    endtask

    task automatic set_instr(input logic [4:0] op, input logic [REG_AW-1:0] rs,
                             input logic [REG_AW-1:0] rt, input logic [DATA_W-1:0] rsd,
                             input logic [DATA_W-1:0] rtd, input logic [REG_AW-1:0] rd);
        in_valid = 1; in_opcode = op; in_rs = rs; in_rt = rt;
        in_rs_data = rsd; in_rt_data = rtd; in_rd = rd; in_use_imm = 0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_opcode", alu_opcode, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_stall", stall_cnt, 0);
        rst_n = 1;
        cycle();

        // ADD r1 = r2 + r3
        set_instr(5'd0, 4'd2, 4'd3, 32'd5, 32'd7, 4'd1);
        cycle();
        in_valid = 0;
        check("add_alu_a", alu_a, 5);
        check("add_alu_b", alu_b, 7);
        check("add_out_rd", out_rd, 1);
        cycle();

        // Forwarding priority, back to back
        set_instr(5'd3, 4'd4, 4'd5, 32'h33, 32'h44, 4'd6);
        ex_fwd_valid = 1; ex_fwd_reg = 4; ex_fwd_data = 32'h11;
        wb_fwd_valid = 1; wb_fwd_reg = 4; wb_fwd_data = 32'h22;
        cycle();
        check("fwd_ex_alu_a", alu_a, 32'h11);
        ex_fwd_valid = 0;
        cycle();
        check("fwd_wb_alu_a", alu_a, 32'h22);
        in_rs = 0; ex_fwd_valid = 1; ex_fwd_reg = 0; wb_fwd_reg = 0;
        cycle();
        check("fwd_r0_alu_a", alu_a, 0);
        ex_fwd_valid = 0; wb_fwd_valid = 0;

        // Load-use stall then capture with the loaded value
        set_instr(5'd1, 4'd2, 4'd7, 32'h55, 32'h66, 4'd8);
        ex_fwd_valid = 1; ex_fwd_reg = 2; ex_fwd_is_load = 1; ex_fwd_data = 32'h0;
        cycle();
        check("lu_bubble", out_valid, 0);
        check("lu_stall", stall_cnt, 1);
        ex_fwd_is_load = 0; ex_fwd_data = 32'h9;
        cycle();
        check("lu_alu_a", alu_a, 32'h9);

        // Immediate: load on rt does not matter
        set_instr(5'd2, 4'd5, 4'd2, 32'h77, 32'h88, 4'd9);
        in_use_imm = 1; in_imm = 32'hFFFF_FFF0;
        ex_fwd_valid = 1; ex_fwd_reg = 2; ex_fwd_is_load = 1;
        cycle();
        check("imm_alu_b", alu_b, 32'hFFFF_FFF0);
        clear_inputs();
        cycle();

        // Backpressure: hold for 3 cycles with a waiting instruction
        set_instr(5'd4, 4'd3, 4'd4, 32'hA, 32'hB, 4'd2);
        cycle();
        set_instr(5'd5, 4'd6, 4'd7, 32'hC, 32'hD, 4'd3);
        out_ready = 0;
        repeat (3) cycle();
        check("bp_alu_a", alu_a, 32'hA);
        // Flush with an incoming instruction: nothing captured
        flush = 1; out_ready = 1;
        cycle();
        flush = 0; in_valid = 0;
        check("flush_out_valid", out_valid, 0);
        cycle();

        // Stall counter saturation
        set_instr(5'd6, 4'd3, 4'd0, 32'h1, 32'h2, 4'd4);
        ex_fwd_valid = 1; ex_fwd_reg = 3; ex_fwd_is_load = 1;
        repeat (9) cycle();
        check("stall_sat", stall_cnt, STALL_MAX);
        clear_inputs();
        cycle();

        // Asynchronous reset while holding
        set_instr(5'd7, 4'd1, 4'd2, 32'hE, 32'hF, 4'd5);
        out_ready = 0;
        cycle();
        in_valid = 0;
        cycle();
        #2;
        rst_n = 0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_alu_a", alu_a, 0);
        check("arst_alu_b", alu_b, 0);
        check("arst_opcode", alu_opcode, 0);
        check("arst_out_rd", out_rd, 0);
        check("arst_stall", stall_cnt, 0);
        sb.delete();
        m_valid = 0;
        m_stall = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        out_ready = 1;
        cycle();
        set_instr(5'd8, 4'd9, 4'd10, 32'h123, 32'h456, 4'd11);
        cycle();
        in_valid = 0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
